// File: rtl/t21_port_ctrl.sv
// Port I/O sequencer for a T21 node: runs one blocking read or write on the
// four neighbour links, resolving the ANY and LAST pseudo-ports.
module t21_port_ctrl #(
   parameter int unsigned DATA_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   // core side
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_write,
   input  logic [2:0]        op_dir,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              op_done,
   output logic [1:0]        last_dir,
   output logic              last_valid,
   // inbound links
   input  logic [DATA_W-1:0] left_in_data,
   input  logic [DATA_W-1:0] right_in_data,
   input  logic [DATA_W-1:0] up_in_data,
   input  logic [DATA_W-1:0] down_in_data,
   input  logic              left_in_ready,
   input  logic              right_in_ready,
   input  logic              up_in_ready,
   input  logic              down_in_ready,
   output logic              left_in_ack,
   output logic              right_in_ack,
   output logic              up_in_ack,
   output logic              down_in_ack,
   // outbound links
   output logic [DATA_W-1:0] left_out_data,
   output logic [DATA_W-1:0] right_out_data,
   output logic [DATA_W-1:0] up_out_data,
   output logic [DATA_W-1:0] down_out_data,
   output logic              left_out_ready,
   output logic              right_out_ready,
   output logic              up_out_ready,
   output logic              down_out_ready,
   input  logic              left_out_ack,
   input  logic              right_out_ack,
   input  logic              up_out_ack,
   input  logic              down_out_ack
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [2:0] DirAny = 3'd4;

   state_e            state_q;
   logic              write_q;
   logic              any_q;
   logic [1:0]        dir_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [1:0]        last_dir_q;
   logic              last_valid_q;
   logic              op_done_q;
   logic [3:0]        in_ack_q;
   logic [3:0]        out_ready_q;

   // Link bundles indexed by direction: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN.
   logic [3:0]        in_rdy;
   logic [3:0]        out_ack;
   logic [DATA_W-1:0] in_data [4];

   always_comb begin
      in_rdy     = {down_in_ready, up_in_ready, right_in_ready, left_in_ready};
      out_ack    = {down_out_ack, up_out_ack, right_out_ack, left_out_ack};
      in_data[0] = left_in_data;
      in_data[1] = right_in_data;
      in_data[2] = up_in_data;
      in_data[3] = down_in_data;
   end

   // Accept-time decode; LAST (and reserved 6/7) with no history becomes NIL.
   logic       acc_any;
   logic       acc_nil;
   logic [1:0] acc_dir;

   always_comb begin
      acc_any = 1'b0;
      acc_nil = 1'b0;
      acc_dir = 2'd0;
      if (op_dir == DirAny) begin
         acc_any = 1'b1;
      end else if (op_dir < DirAny) begin
         acc_dir = op_dir[1:0];
      end else if (last_valid_q) begin
         acc_dir = last_dir_q;
      end else begin
         acc_nil = 1'b1;
      end
   end

   logic [3:0] sel_mask;
   logic [3:0] cand;
   logic       hit;
   logic [1:0] win;

   always_comb begin
      sel_mask = any_q ? 4'b1111 : (4'b0001 << dir_q);
      // Writes only see acks on links we are actually offering.
      cand     = write_q ? (out_ack & out_ready_q) : (in_rdy & sel_mask);
      hit      = |cand;
      if (cand[0]) begin
         win = 2'd0;
      end else if (cand[1]) begin
         win = 2'd1;
      end else if (cand[2]) begin
         win = 2'd2;
      end else begin
         win = 2'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         write_q      <= 1'b0;
         any_q        <= 1'b0;
         dir_q        <= 2'd0;
         wdata_q      <= '0;
         rd_data_q    <= '0;
         last_dir_q   <= 2'd0;
         last_valid_q <= 1'b0;
         op_done_q    <= 1'b0;
         in_ack_q     <= 4'b0000;
         out_ready_q  <= 4'b0000;
      end else begin
         op_done_q <= 1'b0;
         in_ack_q  <= 4'b0000;
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  write_q <= op_write;
                  any_q   <= acc_any;
                  dir_q   <= acc_dir;
                  if (acc_nil) begin
                     state_q   <= StDone;
                     op_done_q <= 1'b1;
                     if (!op_write) begin
                        rd_data_q <= '0;
                     end
                  end else begin
                     state_q <= StWait;
                     if (op_write) begin
                        wdata_q     <= wr_data;
                        out_ready_q <= acc_any ? 4'b1111 : (4'b0001 << acc_dir);
                     end
                  end
               end
            end
            StWait: begin
               if (hit) begin
                  state_q     <= StDone;
                  op_done_q   <= 1'b1;
                  out_ready_q <= 4'b0000;
                  if (!write_q) begin
                     rd_data_q <= in_data[win];
                     in_ack_q  <= 4'b0001 << win;
                  end
                  if (any_q) begin
                     last_dir_q   <= win;
                     last_valid_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign op_ready        = (state_q == StIdle);
   assign op_done         = op_done_q;
   assign rd_data         = rd_data_q;
   assign last_dir        = last_dir_q;
   assign last_valid      = last_valid_q;

   assign left_in_ack     = in_ack_q[0];
   assign right_in_ack    = in_ack_q[1];
   assign up_in_ack       = in_ack_q[2];
   assign down_in_ack     = in_ack_q[3];

   assign left_out_ready  = out_ready_q[0];
   assign right_out_ready = out_ready_q[1];
   assign up_out_ready    = out_ready_q[2];
   assign down_out_ready  = out_ready_q[3];

   assign left_out_data   = wdata_q;
   assign right_out_data  = wdata_q;
   assign up_out_data     = wdata_q;
   assign down_out_data   = wdata_q;

endmodule

// File: tb/tb_t21_port_ctrl.sv
// Directed bench for t21_port_ctrl: hand-computed vectors checked with
// immediate assertions at each step.
module tb_t21_port_ctrl;

   localparam int unsigned DATA_W = 11;

   logic              clk;
   logic              reset;
   logic              op_valid;
   logic              op_ready;
   logic              op_write;
   logic [2:0]        op_dir;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              op_done;
   logic [1:0]        last_dir;
   logic              last_valid;
   logic [DATA_W-1:0] left_in_data, right_in_data, up_in_data, down_in_data;
   logic              left_in_ready, right_in_ready, up_in_ready, down_in_ready;
   logic              left_in_ack, right_in_ack, up_in_ack, down_in_ack;
   logic [DATA_W-1:0] left_out_data, right_out_data, up_out_data, down_out_data;
   logic              left_out_ready, right_out_ready, up_out_ready, down_out_ready;
   logic              left_out_ack, right_out_ack, up_out_ack, down_out_ack;

   int checks = 0;
   int errors = 0;

   logic [3:0] in_ack_v;
   logic [3:0] out_rdy_v;
   assign in_ack_v  = {down_in_ack, up_in_ack, right_in_ack, left_in_ack};
   assign out_rdy_v = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};

   t21_port_ctrl #(.DATA_W(DATA_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_write        (op_write),
      .op_dir          (op_dir),
      .wr_data         (wr_data),
      .rd_data         (rd_data),
      .op_done         (op_done),
      .last_dir        (last_dir),
      .last_valid      (last_valid),
      .left_in_data    (left_in_data),
      .right_in_data   (right_in_data),
      .up_in_data      (up_in_data),
      .down_in_data    (down_in_data),
      .left_in_ready   (left_in_ready),
      .right_in_ready  (right_in_ready),
      .up_in_ready     (up_in_ready),
      .down_in_ready   (down_in_ready),
      .left_in_ack     (left_in_ack),
      .right_in_ack    (right_in_ack),
      .up_in_ack       (up_in_ack),
      .down_in_ack     (down_in_ack),
      .left_out_data   (left_out_data),
      .right_out_data  (right_out_data),
      .up_out_data     (up_out_data),
      .down_out_data   (down_out_data),
      .left_out_ready  (left_out_ready),
      .right_out_ready (right_out_ready),
      .up_out_ready    (up_out_ready),
      .down_out_ready  (down_out_ready),
      .left_out_ack    (left_out_ack),
      .right_out_ack   (right_out_ack),
      .up_out_ack      (up_out_ack),
      .down_out_ack    (down_out_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; op_valid = 1'b0; op_write = 1'b0; op_dir = 3'd0; wr_data = '0;
      left_in_data = '0; right_in_data = '0; up_in_data = '0; down_in_data = '0;
      left_in_ready = 1'b0; right_in_ready = 1'b0; up_in_ready = 1'b0; down_in_ready = 1'b0;
      left_out_ack = 1'b0; right_out_ack = 1'b0; up_out_ack = 1'b0; down_out_ack = 1'b0;
      #1;
      tick();
      tick();
      chk("rst_op_ready", int'(op_ready), 1);
      chk("rst_op_done", int'(op_done), 0);
      chk("rst_last_valid", int'(last_valid), 0);
      chk("rst_last_dir", int'(last_dir), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_out_ready", int'(out_rdy_v), 0);
      chk("rst_in_ack", int'(in_ack_v), 0);
      chk("rst_out_data", int'(left_out_data), 0);
      reset = 1'b1;
      tick();

      // Read LEFT of -999 (11-bit 0x419), data offered from N.
      left_in_data = 11'h419; left_in_ready = 1'b1;
      op_valid = 1'b1; op_write = 1'b0; op_dir = 3'd0;
      tick();
      op_valid = 1'b0;
      chk("rdl_n1_done", int'(op_done), 0);
      chk("rdl_n1_ack", int'(in_ack_v), 0);
      chk("rdl_n1_ready", int'(op_ready), 0);
      tick();
      chk("rdl_n2_done", int'(op_done), 1);
      chk("rdl_n2_ack", int'(in_ack_v), 4'b0001);
      chk("rdl_n2_data", int'(rd_data), 'h419);
      left_in_ready = 1'b0;
      tick();
      chk("rdl_n3_done", int'(op_done), 0);
      chk("rdl_n3_ack", int'(in_ack_v), 0);
      chk("rdl_n3_ready", int'(op_ready), 1);
      chk("rdl_last_valid", int'(last_valid), 0);
      chk("rdl_rd_hold", int'(rd_data), 'h419);

      // Write RIGHT of 0x123, ack arrives at N+5.
      op_valid = 1'b1; op_write = 1'b1; op_dir = 3'd1; wr_data = 11'h123;
      tick();
      op_valid = 1'b0;
      chk("wrr_out_data_r", int'(right_out_data), 'h123);
      chk("wrr_out_data_d", int'(down_out_data), 'h123);
      for (int i = 1; i <= 4; i++) begin
         chk("wrr_wait_ready", int'(out_rdy_v), 4'b0010);
         chk("wrr_wait_done", int'(op_done), 0);
         if (i < 4) tick();
      end
      tick();
      right_out_ack = 1'b1;
      chk("wrr_n5_ready", int'(out_rdy_v), 4'b0010);
      tick();
      right_out_ack = 1'b0;
      chk("wrr_n6_done", int'(op_done), 1);
      chk("wrr_n6_ready", int'(out_rdy_v), 0);
      chk("wrr_n6_in_ack", int'(in_ack_v), 0);
      tick();
      chk("wrr_n7_done", int'(op_done), 0);
      chk("wrr_n7_idle", int'(op_ready), 1);

      // Read ANY with UP=7 and DOWN=9 both offering; UP wins.
      up_in_data = 11'd7; up_in_ready = 1'b1;
      down_in_data = 11'd9; down_in_ready = 1'b1;
      op_valid = 1'b1; op_write = 1'b0; op_dir = 3'd4;
      tick();
      op_valid = 1'b0;
      tick();
      chk("rda_done", int'(op_done), 1);
      chk("rda_data", int'(rd_data), 7);
      chk("rda_ack", int'(in_ack_v), 4'b0100);
      chk("rda_last_dir", int'(last_dir), 2);
      chk("rda_last_valid", int'(last_valid), 1);
      up_in_ready = 1'b0;
      tick();

      // Read LAST now targets UP only; DOWN offering must not complete it.
      op_valid = 1'b1; op_dir = 3'd5;
      tick();
      op_valid = 1'b0;
      tick();
      chk("rdlast_wait_done", int'(op_done), 0);
      chk("rdlast_wait_ack", int'(in_ack_v), 0);
      up_in_data = 11'd5; up_in_ready = 1'b1;
      tick();
      chk("rdlast_done", int'(op_done), 1);
      chk("rdlast_data", int'(rd_data), 5);
      chk("rdlast_ack", int'(in_ack_v), 4'b0100);
      chk("rdlast_last_dir", int'(last_dir), 2);
      up_in_ready = 1'b0; down_in_ready = 1'b0;
      tick();

      // After reset, LAST is NIL.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("nil_last_valid", int'(last_valid), 0);
      chk("nil_rd_cleared", int'(rd_data), 0);
      op_valid = 1'b1; op_write = 1'b0; op_dir = 3'd5;
      tick();
      op_valid = 1'b0;
      chk("nilr_done", int'(op_done), 1);
      chk("nilr_data", int'(rd_data), 0);
      chk("nilr_ack", int'(in_ack_v), 0);
      tick();
      chk("nilr_after", int'(op_done), 0);
      op_valid = 1'b1; op_write = 1'b1; op_dir = 3'd5; wr_data = 11'h055;
      tick();
      op_valid = 1'b0;
      chk("nilw_done", int'(op_done), 1);
      chk("nilw_ready", int'(out_rdy_v), 0);
      tick();
      chk("nilw_ready2", int'(out_rdy_v), 0);
      chk("nilw_discard", int'(left_out_data), 0);

      // Write ANY with LEFT and RIGHT acking together; LEFT wins.
      op_valid = 1'b1; op_write = 1'b1; op_dir = 3'd4; wr_data = 11'h7FF;
      tick();
      op_valid = 1'b0;
      chk("wra_ready", int'(out_rdy_v), 4'b1111);
      chk("wra_data", int'(up_out_data), 'h7FF);
      left_out_ack = 1'b1; right_out_ack = 1'b1;
      tick();
      left_out_ack = 1'b0; right_out_ack = 1'b0;
      chk("wra_done", int'(op_done), 1);
      chk("wra_ready_low", int'(out_rdy_v), 0);
      chk("wra_last_dir", int'(last_dir), 0);
      chk("wra_last_valid", int'(last_valid), 1);
      tick();

      // Reset in the middle of a write WAIT.
      op_valid = 1'b1; op_write = 1'b1; op_dir = 3'd3; wr_data = 11'h007;
      tick();
      op_valid = 1'b0;
      chk("wrd_ready", int'(out_rdy_v), 4'b1000);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mrst_ready", int'(out_rdy_v), 0);
      chk("mrst_done", int'(op_done), 0);
      chk("mrst_op_ready", int'(op_ready), 1);
      chk("mrst_last_valid", int'(last_valid), 0);
      tick();
      chk("mrst_done2", int'(op_done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/t21_port_ctrl.md
# t21_port_ctrl

Port I/O sequencer for a T21 execution node. It executes one blocking read or write at a time on the node's four directional ports (LEFT, RIGHT, UP, DOWN) for the node core, and resolves the ANY and LAST pseudo-ports. It sits between the node's instruction/ALU core and the 11-bit neighbour links, and owns all link handshakes so the core only sees a request/done pair.

## Interface
Parameters:
- DATA_W, 11, signed value width (TIS-100 range fits in 11 bits)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- op_valid  in  1  core requests a port operation; sampled only when op_ready=1
- op_ready  out  1  high in IDLE only
- op_write  in  1  1=write, 0=read
- op_dir  in  3  0 LEFT, 1 RIGHT, 2 UP, 3 DOWN, 4 ANY, 5 LAST; 6/7 reserved, treated as LAST
- wr_data  in  DATA_W  value to write, captured at accept
- rd_data  out  DATA_W  read result, valid when op_done=1, held until next read completes
- op_done  out  1  one-cycle pulse on completion
- last_dir  out  2  direction resolved by the most recent ANY
- last_valid  out  1  last_dir meaningful
- {left,right,up,down}_in_data  in  DATA_W each  neighbour offered data
- {left,right,up,down}_in_ready  in  1 each  neighbour is offering data
- {left,right,up,down}_in_ack  out  1 each  one-cycle consume pulse to that neighbour
- {left,right,up,down}_out_data  out  DATA_W each  all four carry the captured write value
- {left,right,up,down}_out_ready  out  1 each  this node is offering data
- {left,right,up,down}_out_ack  in  1 each  neighbour consumed our offer

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: op_ready=1. On op_valid, capture op_write, op_dir, and wr_data, then go to WAIT.
  - Exception: LAST with last_valid=0 behaves as NIL and goes directly to DONE. A read returns 0; a write is discarded.
- LAST with last_valid=1 is resolved to last_dir at accept.
- WAIT, read:
  - Sample in_ready of the selected direction.
  - ANY checks all four with fixed priority LEFT>RIGHT>UP>DOWN.
  - On a hit, register that direction's in_data into rd_data and record the winner, then go to DONE.
- WAIT, write:
  - out_ready is high on the selected direction, or on all four for ANY.
  - Sample out_ack on the offered directions. The first ack wins; simultaneous acks resolve by the same priority, and losing acks are ignored.
  - On a win, go to DONE.
- DONE:
  - op_done=1 for exactly one cycle.
  - For a read, the winner's in_ack=1 for this cycle only.
  - out_ready is low on all four directions.
  - Return to IDLE next cycle.
- ANY, on completion: last_dir=winner and last_valid=1. Non-ANY operations never change last_dir.
- Neighbour contract:
  - An offering neighbour holds in_ready/in_data stable until it sees in_ack, then drops in_ready the following cycle.
  - A neighbour asserts out_ack only while our out_ready is high.
- rd_data is a pure register copy; no sign or width conversion.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE. All in_ack, out_ready, and op_done are 0. rd_data, out_data, and last_dir are 0, and last_valid is 0. This applies mid-operation too: an in-flight offer is withdrawn the next cycle and no op_done is issued.
- Read with data already offered: op_valid at cycle N, WAIT at N+1, DONE at N+2 (op_done and in_ack high). Minimum latency is 2.
- Write: op_valid at N, out_ready high from N+1. out_ack sampled at cycle M≥N+1 gives out_ready low and op_done at M+1.
- NIL LAST: op_valid at N, op_done at N+1, no port activity.
- op_valid outside IDLE is ignored. Back-to-back operations: the next accept is possible in the cycle after DONE.
- Blocking has no timeout; WAIT persists indefinitely.

## Test plan
- Read LEFT, left_in_data=-999 with left_in_ready held from N: rd_data=-999 and op_done at N+2; left_in_ack pulses only at N+2.
- Write RIGHT of 0x123: right_out_ready from N+1; right_out_ack at N+5 → op_done at N+6, right_out_ready low at N+6, other out_ready never high.
- Read ANY with up and down offering simultaneously (up=7, down=9): rd_data=7, up_in_ack pulses, down_in_ack stays 0, last_dir=2, last_valid=1; a following read LAST completes from UP.
- After reset, read LAST → rd_data=0 and op_done one cycle after accept; write LAST → op_done, all out_ready remain 0.
- Write ANY with left and right acking in the same cycle: completion recorded as LEFT (last_dir=0), all out_ready drop next cycle.
- reset=0 during write WAIT: next cycle all out_ready 0, no op_done, op_ready=1, last_valid=0.
